// File: rtl/posta_pkg.sv
// Shared definitions for the Winograd F(2,3) output-transform stage:
// A^T coefficient rows and the round/ReLU/saturate post-processing helper.
package posta_pkg;

   typedef int coef_vec_t [4];

   // Rows of A^T for F(2,3): y0 = m0+m1+m2, y1 = m1-m2-m3
   localparam coef_vec_t AT_ROW0 = '{1, 1, 1, 0};
   localparam coef_vec_t AT_ROW1 = '{0, 1, -1, -1};

   // Round-half-up arithmetic shift, optional ReLU, then clamp to out_w signed bits
   function automatic logic signed [63:0] sat_round(
      input logic signed [63:0] y,
      input int                 shift,
      input logic               relu,
      input int                 out_w
   );
      logic signed [63:0] v;
      logic signed [63:0] maxV;
      logic signed [63:0] minV;
      if (shift > 0) begin
         v = (y + (64'sd1 <<< (shift - 1))) >>> shift;
      end else begin
         v = y;
      end
      if (relu && (v < 0)) begin
         v = '0;
      end
      maxV = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      minV = -(64'sd1 <<< (out_w - 1));
      if (v > maxV) begin
         v = maxV;
      end else if (v < minV) begin
         v = minV;
      end
      return v;
   endfunction

endpackage

// File: rtl/posta_xform_1d.sv
// Combinational 4->2 one-dimensional Winograd output transform; output grows
// by two bits because each result sums up to three operands.
module posta_xform_1d
   import posta_pkg::*;
#(
   parameter int W = 22
) (
   input  logic signed [W-1:0] i_x0,
   input  logic signed [W-1:0] i_x1,
   input  logic signed [W-1:0] i_x2,
   input  logic signed [W-1:0] i_x3,
   output logic signed [W+1:0] o_y0,
   output logic signed [W+1:0] o_y1
);

   logic signed [W+1:0] w_x [4];

   assign w_x[0] = {{2{i_x0[W-1]}}, i_x0};
   assign w_x[1] = {{2{i_x1[W-1]}}, i_x1};
   assign w_x[2] = {{2{i_x2[W-1]}}, i_x2};
   assign w_x[3] = {{2{i_x3[W-1]}}, i_x3};

   always_comb begin
      o_y0 = '0;
      o_y1 = '0;
      for (int k = 0; k < 4; k++) begin
         if (AT_ROW0[k] > 0) begin
            o_y0 = o_y0 + w_x[k];
         end else if (AT_ROW0[k] < 0) begin
            o_y0 = o_y0 - w_x[k];
         end
         if (AT_ROW1[k] > 0) begin
            o_y1 = o_y1 + w_x[k];
         end else if (AT_ROW1[k] < 0) begin
            o_y1 = o_y1 - w_x[k];
         end
      end
   end

endmodule

// File: rtl/posta_conv_acc.sv
// Multi-channel Winograd F(2,3) output transform: accumulates per-channel 4x4
// product patches, then row pass -> T1 register -> column pass + post-process -> OUT.
module posta_conv_acc
   import posta_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int CH_W    = 6,
   parameter int OUT_W   = 16,
   parameter int SHIFT_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [CH_W-1:0]       cfg_num_ch,
   input  logic [SHIFT_W-1:0]    cfg_shift,
   input  logic                  cfg_relu,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_W*16-1:0]  s_patch_flat,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [OUT_W*4-1:0]    m_patch_flat
);

   localparam int ACC_W = DATA_W + CH_W;
   localparam int T_W   = ACC_W + 2;
   localparam int XF_W  = ACC_W + 4;

   logic signed [ACC_W-1:0] r_acc  [16];
   logic signed [ACC_W-1:0] w_beat [16];
   logic signed [ACC_W-1:0] w_sum  [16];
   logic signed [T_W-1:0]   w_row  [8];
   logic signed [T_W-1:0]   r_t1   [8];
   logic signed [XF_W-1:0]  w_y    [4];
   logic signed [OUT_W-1:0] w_sat  [4];
   logic signed [OUT_W-1:0] r_out  [4];

   logic [CH_W-1:0]    r_ch_cnt;
   logic [CH_W-1:0]    r_n_ch;
   logic [CH_W-1:0]    w_n_ch;
   logic [SHIFT_W-1:0] r_shift;
   logic [SHIFT_W-1:0] r_t1_shift;
   logic               r_relu;
   logic               r_t1_relu;
   logic               r_t1_valid;
   logic               r_m_valid;
   logic               w_first;
   logic               w_last;
   logic               w_t1_adv;
   logic               w_accept;

   // Before a tile's first beat the live config decides whether this beat is also the last
   assign w_first  = (r_ch_cnt == '0);
   assign w_n_ch   = w_first ? cfg_num_ch : r_n_ch;
   assign w_last   = (r_ch_cnt == (w_n_ch - CH_W'(1)));
   assign w_t1_adv = !r_m_valid || m_ready;
   assign s_ready  = !flush && (!w_last || !r_t1_valid || w_t1_adv);
   assign w_accept = s_valid && s_ready;
   assign m_valid  = r_m_valid;

   always_comb begin
      for (int i = 0; i < 16; i++) begin
         w_beat[i] = {{CH_W{s_patch_flat[i*DATA_W+DATA_W-1]}}, s_patch_flat[i*DATA_W +: DATA_W]};
         w_sum[i]  = w_first ? w_beat[i] : (r_acc[i] + w_beat[i]);
      end
   end

   for (genvar c = 0; c < 4; c++) begin : g_row
      posta_xform_1d #(.W(ACC_W)) u_row (
         .i_x0 (w_sum[c]),
         .i_x1 (w_sum[4+c]),
         .i_x2 (w_sum[8+c]),
         .i_x3 (w_sum[12+c]),
         .o_y0 (w_row[c]),
         .o_y1 (w_row[4+c])
      );
   end

   for (genvar r = 0; r < 2; r++) begin : g_col
      posta_xform_1d #(.W(T_W)) u_col (
         .i_x0 (r_t1[r*4]),
         .i_x1 (r_t1[r*4+1]),
         .i_x2 (r_t1[r*4+2]),
         .i_x3 (r_t1[r*4+3]),
         .o_y0 (w_y[r*2]),
         .o_y1 (w_y[r*2+1])
      );
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_sat[i] = OUT_W'(sat_round(64'(w_y[i]), int'(r_t1_shift), r_t1_relu, OUT_W));
      end
      m_patch_flat = '0;
      for (int i = 0; i < 4; i++) begin
         m_patch_flat[i*OUT_W +: OUT_W] = r_out[i];
      end
   end

   // Channel accumulation; config is captured only on a tile's first beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ch_cnt <= '0;
         r_n_ch   <= '0;
         r_shift  <= '0;
         r_relu   <= 1'b0;
         for (int i = 0; i < 16; i++) r_acc[i] <= '0;
      end else if (flush) begin
         r_ch_cnt <= '0;
         for (int i = 0; i < 16; i++) r_acc[i] <= '0;
      end else if (w_accept) begin
         r_ch_cnt <= w_last ? '0 : (r_ch_cnt + CH_W'(1));
         for (int i = 0; i < 16; i++) r_acc[i] <= w_sum[i];
         if (w_first) begin
            r_n_ch  <= cfg_num_ch;
            r_shift <= cfg_shift;
            r_relu  <= cfg_relu;
         end
      end
   end

   // T1 carries the tile's own shift/relu so the next tile may reconfigure freely
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_t1_valid <= 1'b0;
         r_t1_shift <= '0;
         r_t1_relu  <= 1'b0;
         for (int i = 0; i < 8; i++) r_t1[i] <= '0;
      end else if (w_accept && w_last) begin
         r_t1_valid <= 1'b1;
         r_t1_shift <= w_first ? cfg_shift : r_shift;
         r_t1_relu  <= w_first ? cfg_relu : r_relu;
         for (int i = 0; i < 8; i++) r_t1[i] <= w_row[i];
      end else if (w_t1_adv) begin
         r_t1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m_valid <= 1'b0;
         for (int i = 0; i < 4; i++) r_out[i] <= '0;
      end else if (r_t1_valid && w_t1_adv) begin
         r_m_valid <= 1'b1;
         for (int i = 0; i < 4; i++) r_out[i] <= w_sat[i];
      end else if (m_ready) begin
         r_m_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_posta_conv_acc.sv
// Directed bench for posta_conv_acc: expected tiles are queued as stimulus is
// driven and popped by a monitor on each output handshake.
module tb_posta_conv_acc;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         flush;
   logic [5:0]   cfg_num_ch;
   logic [4:0]   cfg_shift;
   logic         cfg_relu;
   logic         s_valid;
   logic         s_ready;
   logic [255:0] s_patch_flat;
   logic         m_valid;
   logic         m_ready;
   logic [63:0]  m_patch_flat;

   int          errors = 0;
   int          checks = 0;
   logic [63:0] expQ [$];
   logic        prevStall = 1'b0;
   logic [63:0] heldData = '0;

   always #5 clk = ~clk;

   posta_conv_acc #(
      .DATA_W  (16),
      .CH_W    (6),
      .OUT_W   (16),
      .SHIFT_W (5)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .cfg_num_ch   (cfg_num_ch),
      .cfg_shift    (cfg_shift),
      .cfg_relu     (cfg_relu),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_patch_flat (s_patch_flat),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_patch_flat (m_patch_flat)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Reference: Y = A^T * M * A computed directly, then round/relu/clamp to 16 bits
   function automatic logic [63:0] modelTile(input longint acc [16], input int shift, input bit relu);
      int          at [2][4];
      logic [63:0] res;
      longint      y;
      longint      v;
      at  = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};
      res = '0;
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 2; c++) begin
            y = 0;
            for (int i = 0; i < 4; i++)
               for (int j = 0; j < 4; j++)
                  y += longint'(at[r][i] * at[c][j]) * acc[i*4+j];
            v = (shift > 0) ? ((y + (longint'(1) <<< (shift - 1))) >>> shift) : y;
            if (relu && v < 0) v = 0;
            if (v > 32767) v = 32767;
            else if (v < -32768) v = -32768;
            res[(r*2+c)*16 +: 16] = v[15:0];
         end
      end
      return res;
   endfunction

   // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge
   task automatic applyStimulus(input logic [255:0] patch);
      int waitCnt = 0;
      s_valid      = 1'b1;
      s_patch_flat = patch;
      @(negedge clk);
      while (!s_ready && waitCnt < 50) begin
         @(negedge clk);
         waitCnt++;
      end
      checkOutput("beatAccept", 64'(s_ready), 64'd1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic sendTile(input int nch, input int shift, input bit relu, input int mode, input int val,
                           input bit useFixed = 1'b0, input logic [63:0] fixedExp = '0,
                           input int stopAfter = -1, input int holdLast = 0, input bit scramble = 1'b0);
      longint             acc [16];
      logic [255:0]       p;
      logic signed [15:0] elem;
      int                 beats;
      beats = (stopAfter < 0) ? nch : stopAfter;
      foreach (acc[i]) acc[i] = 0;
      for (int b = 0; b < beats; b++) begin
         for (int e = 0; e < 16; e++) begin
            case (mode)
               0:       elem = 16'(val);
               1:       elem = (e == 0) ? 16'(val) : 16'sd0;
               default: elem = 16'($urandom_range(0, 4000)) - 16'sd2000;
            endcase
            acc[e] += longint'(elem);
            p[e*16 +: 16] = elem;
         end
         if (b == 0 || !scramble) begin
            cfg_num_ch = 6'(nch);
            cfg_shift  = 5'(shift);
            cfg_relu   = relu;
         end else begin
            cfg_num_ch = 6'd1;
            cfg_shift  = 5'd31;
            cfg_relu   = !relu;
         end
         if (b == nch - 1) expQ.push_back(useFixed ? fixedExp : modelTile(acc, shift, relu));
         if (b == nch - 1 && holdLast > 0) begin
            s_valid      = 1'b1;
            s_patch_flat = p;
            repeat (holdLast) begin
               @(negedge clk);
               checkOutput("lastStall", 64'(s_ready), 64'd0);
            end
            @(posedge clk);
            #1 m_ready = 1'b1;
            @(negedge clk);
            checkOutput("lastResume", 64'(s_ready), 64'd1);
            @(posedge clk);
            #1 s_valid = 1'b0;
         end else begin
            applyStimulus(p);
         end
      end
   endtask

   task automatic drainWait();
      int n = 0;
      while (expQ.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain", 64'(expQ.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   // Output monitor: scoreboard pops on handshake, stability checked while stalled
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prevStall = 1'b0;
         end else begin
            if (prevStall) begin
               checkOutput("holdValid", 64'(m_valid), 64'd1);
               checkOutput("holdData", m_patch_flat, heldData);
            end
            if (m_valid && m_ready) begin
               if (expQ.size() == 0) checkOutput("spuriousOut", 64'(m_valid), 64'd0);
               else checkOutput("tileOut", m_patch_flat, expQ.pop_front());
            end
            prevStall = m_valid && !m_ready;
            heldData  = m_patch_flat;
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1, "[TB] simulation timeout");
   end

   initial begin
      rst_n        = 1'b0;
      flush        = 1'b0;
      cfg_num_ch   = 6'd1;
      cfg_shift    = 5'd0;
      cfg_relu     = 1'b0;
      s_valid      = 1'b0;
      s_patch_flat = '0;
      m_ready      = 1'b1;
      #2;
      checkOutput("rstValid", 64'(m_valid), 64'd0);
      checkOutput("rstData", m_patch_flat, 64'd0);
      #10 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rstReady", 64'(s_ready), 64'd1);
      @(posedge clk);
      #1;

      // Single channel, all ones
      sendTile(1, 0, 1'b0, 0, 1, 1'b1, 64'h0001_FFFD_FFFD_0009);
      drainWait();

      // Four channels, only m(0,0)=100, shift 2; config scrambled after first beat
      sendTile(4, 2, 1'b0, 1, 100, 1'b1, 64'h0000_0000_0000_0064, -1, 0, 1'b1);
      @(negedge clk);
      checkOutput("latencyN1", 64'(m_valid), 64'd0);
      @(negedge clk);
      checkOutput("latencyN2", 64'(m_valid), 64'd1);
      drainWait();

      // Saturation with 64 channels, positive and negative full scale, then ReLU
      sendTile(64, 0, 1'b0, 0, 32767, 1'b1, 64'h7FFF_8000_8000_7FFF);
      sendTile(64, 0, 1'b0, 0, -32768, 1'b1, 64'h8000_7FFF_7FFF_8000);
      sendTile(64, 0, 1'b1, 0, -32768, 1'b1, 64'h0000_7FFF_7FFF_0000);
      drainWait();

      // Random patches checked against the reference model
      for (int t = 0; t < 4; t++) sendTile(3, 4, t[0], 2, 0);
      sendTile(1, 1, 1'b0, 2, 0);
      sendTile(2, 0, 1'b1, 2, 0);
      drainWait();

      // Back-to-back tiles under backpressure
      m_ready = 1'b0;
      sendTile(2, 1, 1'b0, 2, 0);
      sendTile(2, 3, 1'b1, 2, 0);
      sendTile(2, 0, 1'b0, 2, 0, 1'b0, '0, -1, 5);
      drainWait();

      // Reset pulse in the middle of a tile
      sendTile(4, 0, 1'b0, 2, 0, 1'b0, '0, 2);
      rst_n = 1'b0;
      #1;
      checkOutput("midRstValid", 64'(m_valid), 64'd0);
      #4 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("postRstReady", 64'(s_ready), 64'd1);
      checkOutput("postRstValid", 64'(m_valid), 64'd0);
      @(posedge clk);
      #1;
      sendTile(4, 2, 1'b0, 2, 0);
      drainWait();

      // Flush in the middle of a tile; the beat offered during flush is refused
      sendTile(4, 0, 1'b0, 2, 0, 1'b0, '0, 2);
      flush   = 1'b1;
      s_valid = 1'b1;
      @(negedge clk);
      checkOutput("flushReady", 64'(s_ready), 64'd0);
      @(posedge clk);
      #1;
      flush   = 1'b0;
      s_valid = 1'b0;
      sendTile(4, 1, 1'b1, 2, 0);
      drainWait();
      repeat (5) @(negedge clk);
      checkOutput("finalEmpty", 64'(expQ.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
